// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions used by the bridge's requester and by the register
// file completer: bus widths, the default register window base address and
// the completer FSM state type.
// Ports: none (package).
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int unsigned APB_DATA_W = 32;
   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_WAIT_W = 4;

   // Single constant so requester and completer agree on where the window sits.
   localparam logic [APB_ADDR_W-1:0] APB_BASE_ADDR = 32'h0000_A000;

   typedef enum logic {
      ST_IDLE,
      ST_ACCESS
   } apb_cmpl_state_t;

endpackage

// File: rtl/apb_completer_regfile_if.sv
// -----------------------------------------------------------------------------
// apb_completer_regfile_if
// APB bus bundle between a requester (master modport) and a completer (slave
// modport).
// Signals:
//   psel_i     select
//   penable_i  access-phase enable
//   paddr_i    byte address
//   pwrite_i   1 = write, 0 = read
//   pwdata_i   write data
//   prdata_o   read data
//   pready_o   transfer completion
//   pslverr_o  error response, qualified by pready_o
// -----------------------------------------------------------------------------
interface apb_completer_regfile_if;
   import apb_pkg::*;

   logic                  psel_i;
   logic                  penable_i;
   logic [APB_ADDR_W-1:0] paddr_i;
   logic                  pwrite_i;
   logic [APB_DATA_W-1:0] pwdata_i;
   logic [APB_DATA_W-1:0] prdata_o;
   logic                  pready_o;
   logic                  pslverr_o;

   modport master (
      output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
      input  prdata_o, pready_o, pslverr_o
   );

   modport slave (
      input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
      output prdata_o, pready_o, pslverr_o
   );

endinterface

// File: rtl/apb_reg_array.sv
// -----------------------------------------------------------------------------
// apb_reg_array
// NUM_REGS x 32-bit register storage with one synchronous write port and one
// combinational read port sharing a single word index.
// Ports:
//   clk       clock
//   preset_n  asynchronous active-low reset, loads RESET_VAL everywhere
//   we        write enable
//   index     word index for both write and read
//   wdata     write data
//   rdata     combinational read data at index
// -----------------------------------------------------------------------------
module apb_reg_array
   import apb_pkg::*;
#(
   parameter int unsigned           NUM_REGS  = 8,
   parameter logic [APB_DATA_W-1:0] RESET_VAL = '0,
   parameter int unsigned           IDX_W     = 3
) (
   input  logic                  clk,
   input  logic                  preset_n,
   input  logic                  we,
   input  logic [IDX_W-1:0]      index,
   input  logic [APB_DATA_W-1:0] wdata,
   output logic [APB_DATA_W-1:0] rdata
);

   logic [APB_DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk or negedge preset_n) begin
      if (!preset_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem[i] <= RESET_VAL;
         end
      end else if (we) begin
         mem[index] <= wdata;
      end
   end

   assign rdata = mem[index];

endmodule

// File: rtl/apb_completer_regfile.sv
// -----------------------------------------------------------------------------
// apb_completer_regfile
// APB completer exposing NUM_REGS word registers at BASE_ADDR. Each transfer
// is stretched by WAIT_STATES cycles of pready_o low; out-of-window or
// misaligned addresses complete with pslverr_o and have no effect.
// Ports:
//   clk       shared AHB/APB clock
//   preset_n  asynchronous active-low reset
//   bus       APB slave modport (psel_i, penable_i, paddr_i, pwrite_i,
//             pwdata_i in; prdata_o, pready_o, pslverr_o out)
// -----------------------------------------------------------------------------
module apb_completer_regfile
   import apb_pkg::*;
#(
   parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = APB_BASE_ADDR,
   parameter int unsigned           NUM_REGS    = 8,
   parameter int unsigned           WAIT_STATES = 1,
   parameter logic [APB_DATA_W-1:0] RESET_VAL   = '0
) (
   input  logic                   clk,
   input  logic                   preset_n,
   apb_completer_regfile_if.slave bus
);

   localparam int unsigned           IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [APB_ADDR_W-1:0] WINDOW    = APB_ADDR_W'(NUM_REGS * 4);
   localparam logic [APB_WAIT_W-1:0] WAIT_LOAD = APB_WAIT_W'(WAIT_STATES);

   apb_cmpl_state_t       state, state_d;
   logic [APB_WAIT_W-1:0] cnt, cnt_d;
   logic                  capture;
   logic                  we;
   logic                  ready;

   logic [APB_ADDR_W-1:0] addr_q;
   logic                  write_q;
   logic [APB_DATA_W-1:0] wdata_q;

   logic [APB_ADDR_W-1:0] offset;
   logic                  hit;
   logic [IDX_W-1:0]      mem_index;
   logic [APB_DATA_W-1:0] rdata;

   // Control state: the only registers that need reset.
   always_ff @(posedge clk or negedge preset_n) begin
      if (!preset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Setup-phase capture; the access phase works only from these copies so
   // bus activity during wait states cannot disturb the transfer.
   always_ff @(posedge clk) begin
      if (capture) begin
         addr_q  <= bus.paddr_i;
         write_q <= bus.pwrite_i;
         wdata_q <= bus.pwdata_i;
      end
   end

   // Unsigned subtraction: addresses below the base wrap to a huge offset and
   // fall outside the window without a separate lower-bound compare.
   assign offset    = addr_q - BASE_ADDR;
   assign hit       = (offset < WINDOW) && (addr_q[1:0] == 2'b00);
   assign mem_index = offset[IDX_W+1:2];

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      capture = 1'b0;
      we      = 1'b0;
      ready   = 1'b0;
      case (state)
         ST_IDLE: begin
            // An enable without a preceding setup is not a transfer.
            if (bus.psel_i && !bus.penable_i) begin
               capture = 1'b1;
               cnt_d   = WAIT_LOAD;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!bus.psel_i) begin
               state_d = ST_IDLE;
            end else if (bus.penable_i) begin
               if (cnt == '0) begin
                  ready   = 1'b1;
                  we      = write_q & hit;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt - 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   apb_reg_array #(
      .NUM_REGS  (NUM_REGS),
      .RESET_VAL (RESET_VAL),
      .IDX_W     (IDX_W)
   ) u_regs (
      .clk      (clk),
      .preset_n (preset_n),
      .we       (we),
      .index    (mem_index),
      .wdata    (wdata_q),
      .rdata    (rdata)
   );

   assign bus.pready_o  = ready;
   assign bus.pslverr_o = ready & ~hit;
   assign bus.prdata_o  = (ready && hit && !write_q) ? rdata : '0;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_completer_regfile
// Directed bench for apb_completer_regfile. Two instances share one driven
// bus: dut0 with zero wait states and dut3 with three; tgt picks which one
// sees psel_i and whose outputs are observed.
// -----------------------------------------------------------------------------
module tb_apb_completer_regfile;
   import apb_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_A000;
   localparam logic [31:0] RVAL = 32'h0000_0000;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          waits;
   } exp_t;

   logic        clk = 1'b0;
   logic        preset_n;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        tgt;

   logic        pready, pslverr;
   logic [31:0] prdata;

   logic [31:0] m0 [8];
   logic [31:0] m3 [8];
   exp_t        sbq [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_completer_regfile_if if0 ();
   apb_completer_regfile_if if3 ();

   assign if0.psel_i    = psel & ~tgt;
   assign if0.penable_i = penable;
   assign if0.paddr_i   = paddr;
   assign if0.pwrite_i  = pwrite;
   assign if0.pwdata_i  = pwdata;
   assign if3.psel_i    = psel & tgt;
   assign if3.penable_i = penable;
   assign if3.paddr_i   = paddr;
   assign if3.pwrite_i  = pwrite;
   assign if3.pwdata_i  = pwdata;

   assign pready  = tgt ? if3.pready_o  : if0.pready_o;
   assign pslverr = tgt ? if3.pslverr_o : if0.pslverr_o;
   assign prdata  = tgt ? if3.prdata_o  : if0.prdata_o;

   apb_completer_regfile #(
      .BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_STATES(0), .RESET_VAL(RVAL)
   ) dut0 (
      .clk(clk), .preset_n(preset_n), .bus(if0)
   );

   apb_completer_regfile #(
      .BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_STATES(3), .RESET_VAL(RVAL)
   ) dut3 (
      .clk(clk), .preset_n(preset_n), .bus(if3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_models();
      for (int i = 0; i < 8; i++) begin
         m0[i] = RVAL;
         m3[i] = RVAL;
      end
   endtask

   // One full APB transfer starting just after a clock edge. The expectation
   // is queued before driving and popped when pready_o is observed.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [31:0] data, input bit scramble);
      exp_t e;
      bit   ok;
      int   idx;
      int   cyc;
      bit   done;
      ok  = (addr >= BASE) && (addr < BASE + 32'd32) && (addr[1:0] == 2'b00);
      idx = ok ? int'((addr - BASE) >> 2) : 0;
      e.tag   = tag;
      e.err   = !ok;
      e.rdata = 32'h0;
      e.waits = tgt ? 3 : 0;
      if (!wr && ok) e.rdata = tgt ? m3[idx] : m0[idx];
      sbq.push_back(e);
      if (wr && ok) begin
         if (tgt) m3[idx] = data;
         else     m0[idx] = data;
      end

      psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
      @(posedge clk); #1;
      penable = 1'b1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 32) begin
         @(negedge clk);
         cyc++;
         if (pready === 1'b1) begin
            done = 1'b1;
         end else begin
            chk({tag, " wait prdata"}, prdata, 32'h0);
            chk({tag, " wait pslverr"}, {31'h0, pslverr}, 32'h0);
            if (scramble) begin
               paddr  = $urandom;
               pwdata = $urandom;
               pwrite = ~wr;
            end
         end
      end
      e = sbq.pop_front();
      chk({e.tag, " access cycles"}, cyc, e.waits + 1);
      chk({e.tag, " pready"}, {31'h0, pready}, 32'h1);
      chk({e.tag, " prdata"}, prdata, e.rdata);
      chk({e.tag, " pslverr"}, {31'h0, pslverr}, {31'h0, e.err});
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         xfer($sformatf("%s r%0d", tag, i), BASE + 32'(i * 4), 1'b0, 32'h0, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      preset_n = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'h0; pwdata = 32'h0; tgt = 1'b0;
      clear_models();

      repeat (3) @(posedge clk);
      #1;
      chk("rst pready0",  {31'h0, if0.pready_o},  32'h0);
      chk("rst pslverr0", {31'h0, if0.pslverr_o}, 32'h0);
      chk("rst prdata0",  if0.prdata_o,           32'h0);
      chk("rst pready3",  {31'h0, if3.pready_o},  32'h0);
      chk("rst prdata3",  if3.prdata_o,           32'h0);
      preset_n = 1'b1;
      @(posedge clk); #1;

      // Zero-wait write then read back.
      tgt = 1'b0;
      xfer("w0 wr A004", 32'hA004, 1'b1, 32'hDEAD_BEEF, 1'b0);
      xfer("w0 rd A004", 32'hA004, 1'b0, 32'h0, 1'b0);

      // Enable without setup must be ignored.
      psel = 1'b1; penable = 1'b1; paddr = 32'hA004; pwrite = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("no setup pready", {31'h0, pready}, 32'h0);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;

      // Three wait states, bus scrambled while waiting.
      tgt = 1'b1;
      xfer("w3 rd A000", 32'hA000, 1'b0, 32'h0, 1'b1);

      // Error decode on the zero-wait instance.
      tgt = 1'b0;
      xfer("err A020", 32'hA020, 1'b1, 32'h1111_1111, 1'b0);
      xfer("err A002", 32'hA002, 1'b1, 32'h2222_2222, 1'b0);
      xfer("err 9FFC", 32'h9FFC, 1'b1, 32'h3333_3333, 1'b0);
      xfer("err rd A020", 32'hA020, 1'b0, 32'h0, 1'b0);
      read_all("after err");

      // Back-to-back on both instances.
      for (int i = 0; i < 8; i++)
         xfer($sformatf("b2b0 w%0d", i), BASE + 32'(i * 4), 1'b1, 32'h1000_0000 + 32'(i), 1'b0);
      read_all("b2b0");
      tgt = 1'b1;
      for (int i = 0; i < 8; i++)
         xfer($sformatf("b2b3 w%0d", i), BASE + 32'(i * 4), 1'b1, 32'h1000_0000 + 32'(i), 1'b1);
      read_all("b2b3");

      // Abort: drop psel during a wait state of a write to A008.
      psel = 1'b1; penable = 1'b0; paddr = 32'hA008; pwrite = 1'b1; pwdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      chk("abort wait pready", {31'h0, pready}, 32'h0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort idle pready", {31'h0, pready}, 32'h0);
      end
      @(posedge clk); #1;
      xfer("abort rd A008", 32'hA008, 1'b0, 32'h0, 1'b0);
      xfer("abort next wr", 32'hA010, 1'b1, 32'h0BAD_F00D, 1'b0);
      xfer("abort next rd", 32'hA010, 1'b0, 32'h0, 1'b0);

      // Reset pulse while a W=3 write is presenting pready.
      psel = 1'b1; penable = 1'b0; paddr = 32'hA00C; pwrite = 1'b1; pwdata = 32'hCAFE_0001;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst-mid pready before", {31'h0, pready}, 32'h1);
      #1;
      preset_n = 1'b0;
      #1;
      chk("rst-mid pready",  {31'h0, pready},  32'h0);
      chk("rst-mid pslverr", {31'h0, pslverr}, 32'h0);
      chk("rst-mid prdata",  prdata,           32'h0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      clear_models();
      @(posedge clk); #1;
      preset_n = 1'b1;
      @(posedge clk); #1;
      read_all("post-rst3");
      xfer("post-rst3 wr A01C", 32'hA01C, 1'b1, 32'h7777_0007, 1'b0);
      xfer("post-rst3 rd A01C", 32'hA01C, 1'b0, 32'h0, 1'b0);
      tgt = 1'b0;
      read_all("post-rst0");

      chk("scoreboard drained", 32'(sbq.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
